uart_tx_fifo: RTL

Parametrised, synthesizable UART transmitter with an input FIFO, for femto SoC peripherals and for benches that drive RXD.
- Replaces hand-written byte-serialising tasks with a cycle-exact block.
- Configurable frame format: data width, parity, stop bits and inter-frame idle gap.
- Accepts bytes on a valid/ready stream, buffers them, and sends them back-to-back on txd.

---
 rtl/uart_tx_fifo.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_fifo                                                    |
// | Purpose  : UART transmitter fed by a circular-buffer FIFO. Bytes accepted  |
// |            on a valid/ready stream are queued and sent back-to-back on    |
// |            txd with a configurable frame format (data width, parity,      |
// |            stop bits, inter-frame idle gap).                               |
// | Ports    : clk        - system clock                                      |
// |            reset      - asynchronous, active-high reset                   |
// |            wr_data    - character to send (DATA_BITS wide)                |
// |            wr_valid   - wr_data valid                                     |
// |            wr_ready   - FIFO not full; write on wr_valid && wr_ready      |
// |            txd        - serial line, idle high, driven from a flop        |
// |            busy       - a frame (including its gap) is in progress        |
// |            fifo_level - entries queued, excluding the frame being shifted |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]       LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]        GAP_LAST  = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;

  // Transmitter state
  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;

  assign wr_ready   = (level_q != LEVEL_FULL);
  assign fifo_level = level_q;
  assign busy       = (state_q != S_IDLE);
  assign txd        = txd_q;

  assign push    = wr_valid && wr_ready;
  // IDLE takes the head as soon as one is present, including the clock right
  // after STOP/GAP, which yields exactly one idle clock between frames.
  assign pop     = (state_q == S_IDLE) && (level_q != '0);
  assign bit_end = (baud_q == BAUD_LAST);
  assign head    = mem_q[rd_ptr_q];

  // FIFO pointer / level update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Frame sequencer: every state except IDLE advances only on bit boundaries.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;

    if (state_q == S_IDLE) begin
      baud_d = '0;
      bit_d  = '0;
      if (pop) begin
        shift_d = head;
        // Odd parity: bit set when the data holds an even count of ones.
        par_d   = (PARITY == 1) ? ~(^head) : (^head);
        state_d = S_START;
      end
    end else begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = '0;
          end
          S_DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == DATA_LAST) begin
              bit_d   = '0;
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
          S_PAR: begin
            state_d = S_STOP;
            bit_d   = '0;
          end
          S_STOP: begin
            if (bit_q == STOP_LAST) begin
              bit_d   = '0;
              state_d = (GAP_BITS != 0) ? S_GAP : S_IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
          S_GAP: begin
            if (bit_q == GAP_LAST) begin
              bit_d   = '0;
              state_d = S_IDLE;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
          default: begin
            state_d = S_IDLE;
            bit_d   = '0;
          end
        endcase
      end
    end
  end

  // Line level registered from the current state, so txd trails the state
  // register by one clock and never glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_q[0];
      S_PAR:   txd_d = par_q;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
    end
  end

  // Storage needs no reset: only entries covered by level_q are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire
